// File: rtl/md_unit_ctrl_if.sv
// Pipeline-side bundle for the multiply/divide unit: E-stage operands and opcode,
// D-stage class hint, plus the unit's busy/stall/read-back and HI/LO outputs.
interface md_unit_ctrl_if;
  logic        E_start;
  logic [3:0]  E_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] E_MDout;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_start, E_op, E_A, E_B, D_md,
    input  busy, md_stall, E_MDout, HI, LO
  );

  modport slave (
    input  E_start, E_op, E_A, E_B, D_md,
    output busy, md_stall, E_MDout, HI, LO
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO; models MULT/DIV latency with a busy counter.
// Optional MDU_MADD_EN adds MADD/MADDU (accumulate into {HI,LO}, MULT_CYCLES latency).
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  md_unit_ctrl_if.slave mdu
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,  OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3,
    OP_DIVU  = 4'd4,  OP_MTHI  = 4'd5, OP_MTLO  = 4'd6, OP_MFHI = 4'd7,
    OP_MFLO  = 4'd8,  OP_MADD  = 4'd9, OP_MADDU = 4'd10
  } op_e;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q, sh_hi, sh_lo;
  logic             sh_commit;

  op_e         op;
  logic [63:0] prod_s, prod_u;
  logic        div_nz;
  logic [31:0] divisor, quot_s, rem_s, quot_u, rem_u;

  assign op     = op_e'(mdu.E_op);
  assign prod_s = {{32{mdu.E_A[31]}}, mdu.E_A} * {{32{mdu.E_B[31]}}, mdu.E_B};
  assign prod_u = {32'd0, mdu.E_A} * {32'd0, mdu.E_B};
  // Divisor forced to 1 on zero so the dividers never see /0; the result is discarded anyway.
  assign div_nz  = |mdu.E_B;
  assign divisor = div_nz ? mdu.E_B : 32'd1;
  assign quot_s  = $signed(mdu.E_A) / $signed(divisor);
  assign rem_s   = $signed(mdu.E_A) % $signed(divisor);
  assign quot_u  = mdu.E_A / divisor;
  assign rem_u   = mdu.E_A % divisor;

  logic             start_ok;
  logic             res_commit;
  logic [31:0]      res_hi, res_lo;
  logic [CNT_W-1:0] res_cycles;

  always_comb begin
    // NOTE: every output gets a default up front so no path through the case infers a latch.
    start_ok   = 1'b0;
    res_commit = 1'b1;
    res_hi     = '0;
    res_lo     = '0;
    res_cycles = CNT_W'(MULT_CYCLES);
    case (op)
      OP_MULT:  begin start_ok = mdu.E_start; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin start_ok = mdu.E_start; {res_hi, res_lo} = prod_u; end
      OP_DIV: begin
        start_ok   = mdu.E_start;
        res_cycles = CNT_W'(DIV_CYCLES);
        res_commit = div_nz;
        res_lo     = quot_s;
        res_hi     = rem_s;
      end
      OP_DIVU: begin
        start_ok   = mdu.E_start;
        res_cycles = CNT_W'(DIV_CYCLES);
        res_commit = div_nz;
        res_lo     = quot_u;
        res_hi     = rem_u;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin start_ok = mdu.E_start; {res_hi, res_lo} = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin start_ok = mdu.E_start; {res_hi, res_lo} = {hi_q, lo_q} + prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      sh_hi     <= '0;
      sh_lo     <= '0;
      sh_commit <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            sh_hi     <= res_hi;
            sh_lo     <= res_lo;
            sh_commit <= res_commit;
            cnt       <= res_cycles;
            state     <= ST_BUSY;
          end else if (op == OP_MTHI) begin
            hi_q <= mdu.E_A;
          end else if (op == OP_MTLO) begin
            lo_q <= mdu.E_A;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            if (sh_commit) begin
              hi_q <= sh_hi;
              lo_q <= sh_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mdu.busy     = (state == ST_BUSY);
  assign mdu.md_stall = mdu.D_md & (mdu.busy | mdu.E_start);
  assign mdu.E_MDout  = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'd0;
  assign mdu.HI       = hi_q;
  assign mdu.LO       = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a cycle-scheduled behavioural model.
module tb_md_unit_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  md_unit_ctrl_if ifc ();

  md_unit_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (ifc)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Operation result from the ISA definition: {commit, hi, lo}.
  function automatic logic [64:0] model_op(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {hi, lo};
    case (op)
      4'd1: return {1'b1, 64'(sa * sb)};
      4'd2: return {1'b1, 64'(ua * ub)};
      4'd3: begin
        if (b == 32'd0) return {1'b0, hi, lo};
        q = sa / sb;
        r = sa - q * sb;
        return {1'b1, r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {1'b0, hi, lo};
        uq = ua / ub;
        ur = ua - uq * ub;
        return {1'b1, ur[31:0], uq[31:0]};
      end
      4'd9:  return {1'b1, 64'(acc + 64'(sa * sb))};
      4'd10: return {1'b1, 64'(acc + ua * ub)};
      default: return {1'b0, hi, lo};
    endcase
  endfunction

  function automatic bit model_starts(input logic st, input logic [3:0] op);
`ifdef MDU_MADD_EN
    return st && ((op >= 4'd1 && op <= 4'd4) || op == 4'd9 || op == 4'd10);
`else
    return st && (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  longint      cyc = 0;      // index of the cycle that ends at the next rising edge
  longint      m_end = 0;    // last busy cycle of the pending operation
  bit          m_active = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [64:0] m_pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_hi     <= '0;
      m_lo     <= '0;
    end else if (m_active) begin
      if (cyc == m_end) begin
        m_active <= 1'b0;
        if (m_pend[64]) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
        end
      end
    end else if (model_starts(ifc.E_start, ifc.E_op)) begin
      m_active <= 1'b1;
      m_pend   <= model_op(ifc.E_op, ifc.E_A, ifc.E_B, m_hi, m_lo);
      m_end    <= cyc + ((ifc.E_op == 4'd3 || ifc.E_op == 4'd4) ? DC : MC);
    end else if (ifc.E_op == 4'd5) begin
      m_hi <= ifc.E_A;
    end else if (ifc.E_op == 4'd6) begin
      m_lo <= ifc.E_A;
    end
    cyc <= cyc + 1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     {31'd0, ifc.busy}, {31'd0, m_active});
      check("md_stall", {31'd0, ifc.md_stall}, {31'd0, ifc.D_md & (m_active | ifc.E_start)});
      check("E_MDout",  ifc.E_MDout, (ifc.E_op == 4'd7) ? m_hi : (ifc.E_op == 4'd8) ? m_lo : 32'd0);
      check("HI",       ifc.HI, m_hi);
      check("LO",       ifc.LO, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] op, input logic [31:0] a, b, input logic dmd);
    ifc.E_start = st;
    ifc.E_op    = op;
    ifc.E_A     = a;
    ifc.E_B     = b;
    ifc.D_md    = dmd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  // Issue a one-cycle op, then count busy cycles (bounded).
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, b,
                        input int exp_cycles);
    int n;
    drive(1'b1, op, a, b, 1'b0);
    step();
    idle();
    n = 0;
    while (ifc.busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check({name, "_busy_cycles"}, n, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    step();
    step();
    chk_en = 1'b1;
    reset = 1'b0;
    check("reset_busy", {31'd0, ifc.busy}, 32'd0);
    check("reset_hi", ifc.HI, 32'd0);
    check("reset_lo", ifc.LO, 32'd0);
    check("reset_stall", {31'd0, ifc.md_stall}, 32'd0);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, MC);
    check("mult_hi", ifc.HI, 32'hFFFF_FFFF);
    check("mult_lo", ifc.LO, 32'hFFFF_FFFA);

    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, DC);
    check("div_lo", ifc.LO, 32'hFFFF_FFFD);
    check("div_hi", ifc.HI, 32'hFFFF_FFFF);

    run_op("divu", 4'd4, 32'd7, 32'd2, DC);
    check("divu_lo", ifc.LO, 32'd3);
    check("divu_hi", ifc.HI, 32'd1);

    drive(1'b0, 4'd5, 32'h1234, 32'd0, 1'b0);
    step();
    drive(1'b0, 4'd7, 32'd0, 32'd0, 1'b0);
    #1 check("mthi_then_mfhi", ifc.E_MDout, 32'h1234);
    drive(1'b0, 4'd6, 32'h5678, 32'd0, 1'b0);
    step();
    run_op("divu0", 4'd4, 32'd99, 32'd0, DC);
    check("divu0_hi", ifc.HI, 32'h1234);
    check("divu0_lo", ifc.LO, 32'h5678);

    // MULTU with a dependent md instruction waiting in D.
    drive(1'b1, 4'd2, 32'h0001_0000, 32'h0001_0000, 1'b1);
    #1 check("stall_start_cycle", {31'd0, ifc.md_stall}, 32'd1);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
    n = 0;
    while (ifc.md_stall === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("stall_busy_cycles", n, MC);
    check("multu_hi", ifc.HI, 32'd1);
    check("multu_lo", ifc.LO, 32'd0);
    drive(1'b0, 4'd7, 32'd0, 32'd0, 1'b1);
    #1 check("mfhi_after_multu", ifc.E_MDout, 32'd1);
    check("stall_after_busy", {31'd0, ifc.md_stall}, 32'd0);
    step();

    // Reset during the third busy cycle of a DIV.
    drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    step();
    idle();
    step();
    step();
    check("third_busy_cycle", {31'd0, ifc.busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_busy", {31'd0, ifc.busy}, 32'd0);
    check("midreset_hi", ifc.HI, 32'd0);
    check("midreset_lo", ifc.LO, 32'd0);
    run_op("mult_after_reset", 4'd1, 32'd3, 32'd4, MC);
    check("mult_after_reset_lo", ifc.LO, 32'd12);

    // MADDU accumulate (or no-op without the feature).
    drive(1'b0, 4'd5, 32'd0, 32'd0, 1'b0);
    step();
    drive(1'b0, 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    step();
`ifdef MDU_MADD_EN
    run_op("maddu", 4'd10, 32'd1, 32'd1, MC);
    check("maddu_hi", ifc.HI, 32'd1);
    check("maddu_lo", ifc.LO, 32'd0);
`else
    run_op("maddu_off", 4'd10, 32'd1, 32'd1, 0);
    check("maddu_off_hi", ifc.HI, 32'd0);
    check("maddu_off_lo", ifc.LO, 32'hFFFF_FFFF);
`endif

    // Randomized traffic; mostly respects the hazard unit, occasionally probes ignore-while-busy.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      if (m_active && $urandom_range(0, 3) != 0)
        op = ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd8;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      drive((op >= 4'd1 && op <= 4'd4) || op == 4'd9 || op == 4'd10, op, a, b,
            1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 249) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multiply/divide sequencer for the E stage of the five-stage pipeline. Owns the HI/LO registers and models the multi-cycle latency of MULT/MULTU/DIV/DIVU with a busy counter. Serves MTHI/MTLO/MFHI/MFLO. Raises a stall request that the hazard unit ORs into its global stall, so a D-stage multiply/divide-class instruction is held while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; clears all state
- E_start  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU(/MADD/MADDU), qualified by E_op
- E_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9 MADD, 10 MADDU; others NONE
- E_A  in  32  forwarded rs value
- E_B  in  32  forwarded rt value
- D_md  in  1  D-stage instruction is any multiply/divide-class op (codes 1–10)
- busy  out  1  operation in progress
- md_stall  out  1  stall request to hazard unit
- E_MDout  out  32  HI for MFHI, LO for MFLO, else 0 (combinational)
- HI, LO  out  32 each  architectural registers

## Operation
- States: IDLE, BUSY. Counter cnt, 4 bits minimum.
- IDLE → BUSY when E_start=1 and E_op ∈ {1,2,3,4} (plus {9,10} with macro).
  - Compute result from E_A/E_B that cycle and latch into shadow pair (sh_hi, sh_lo).
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
- BUSY: cnt decrements each cycle. When cnt==1: HI←sh_hi, LO←sh_lo, state→IDLE.
- Arithmetic:
  - MULT: {HI,LO}=signed 32×32→64.
  - MULTU: same, unsigned.
  - DIV: LO=quotient, HI=remainder; signed, truncate toward zero, remainder takes dividend's sign.
  - DIVU: same, unsigned.
- Divide by zero (E_B==0): still BUSY for DIV_CYCLES; HI/LO unchanged at completion.
- MTHI/MTLO in IDLE: HI or LO ← E_A at next edge. No busy.
- MFHI/MFLO: read current HI/LO via E_MDout. No state change.
- E_start or E_op 5/6 while BUSY: ignored. The hazard unit never allows this.
- md_stall = D_md & (busy | E_start).
- Reset: state IDLE, cnt 0, HI=LO=0, shadows 0, busy=0, md_stall=0 (given D_md=0). Reset mid-operation discards the pending result.

## Timing
- Start sampled at edge t. busy=1 for cycles t+1 … t+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO new values visible from cycle t+N+1, same cycle busy falls.
- A D-stage md instruction behind a starting op stalls in the start cycle (E_start term), then for all N busy cycles. It enters E at cycle t+N+1 and reads updated HI/LO.
- Back-to-back: a new start in the cycle after busy falls is accepted.
- MTHI/MTLO: write at next edge. A following MFHI/MFLO in E one cycle later sees the new value. No bypass within the same cycle.
- E_MDout and md_stall are combinational. busy, HI and LO are registered.

## Configuration
- MDU_MADD_EN defined: E_op 9/10 are legal.
  - MADD: {HI,LO} ← {HI,LO} + signed(E_A×E_B).
  - MADDU: same, unsigned.
  - Both take MULT_CYCLES. The accumulate base is the HI/LO value at start.
- MDU_MADD_EN undefined: codes 9/10 are treated as NONE. No busy, no state change, no extra adder synthesized.

## Test plan
- MULT, E_A=0xFFFFFFFE (−2), E_B=3 → busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV, E_A=−7, E_B=2 → busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with 7,2 → LO=3, HI=1.
- DIVU with E_B=0 after MTHI 0x1234 / MTLO 0x5678 → busy 10 cycles; HI/LO stay 0x1234/0x5678.
- MULTU 0x10000×0x10000 with D_md=1 held → md_stall=1 on start cycle plus 5 busy cycles, 0 after. HI=1, LO=0. MFHI returns 1.
- Reset asserted on 3rd busy cycle of DIV → next cycle busy=0, HI=LO=0. New MULT starts normally.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then MADDU 1×1 → HI=1, LO=0 after 5 cycles. Without the macro: same op leaves HI/LO and busy unchanged.
